// File: rtl/spi_slave_port_if.sv
// Register-window bus shared by the CPU and the SPI slave endpoint.
// The CPU drives the address, strobes and write data; the slave returns
// registered read data and a registered interrupt.
interface spi_slave_port_if;
    logic [15:0] data_from_cpu;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic        spi_select;
    logic [15:0] data_to_cpu;
    logic        irq;

    modport master (
        output data_from_cpu,
        output mem_addr,
        output read_n,
        output write_n,
        output spi_select,
        input  data_to_cpu,
        input  irq
    );

    modport slave (
        input  data_from_cpu,
        input  mem_addr,
        input  read_n,
        input  write_n,
        input  spi_select,
        output data_to_cpu,
        output irq
    );
endinterface

// File: rtl/spi_slave_port.sv
// SPI slave endpoint (CPOL=0, CPHA=0, MSB first) with a CPU register window:
// rxdata, txdata, status and control. SCLK, SS_n and MOSI are oversampled on
// clk; received bytes land in rx_holding, MISO is driven from a shift register
// loaded from the tx holding register at the start of each frame.
module spi_slave_port #(
    parameter int unsigned DATABITS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_slave_port_if.slave    bus,
    input  logic               SCLK,
    input  logic               MOSI,
    input  logic               SS_n,
    output logic               MISO,
    output logic               MISO_oe
);

    localparam int unsigned CNTW      = $clog2(DATABITS + 1);
    localparam logic [15:0] CTRL_MASK = 16'h01DC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_WAITF
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_flush;
    logic                   r_sclk_hist;
    logic                   r_ss_hist;
    logic                   r_ss_armed;

    logic w_sclk;
    logic w_ss;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_ssact;

    logic [DATABITS-1:0] r_shift_rx;
    logic [DATABITS-1:0] r_shift_tx;
    logic [DATABITS-1:0] r_rx_hold;
    logic [DATABITS-1:0] r_tx_hold;
    logic [CNTW-1:0]     r_bitcnt;
    logic                r_tx_primed;
    logic                r_tur_pending;

    logic r_rrdy;
    logic r_roe;
    logic r_toe;
    logic r_tur;
    logic [15:0] r_control;

    logic r_rd_req_d;
    logic r_wr_req_d;
    logic w_rd_req;
    logic w_wr_req;
    logic w_rd_stb;
    logic w_wr_stb;
    logic w_rx_read;
    logic w_tx_write;
    logic w_stat_write;
    logic w_ctrl_write;

    logic [15:0] w_status;
    logic [15:0] w_rdata;
    logic [15:0] r_data_to_cpu;
    logic        r_irq;

    // Pin synchronizers, edge-history flops and post-reset arming of SS_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_ss_hist   <= 1'b1;
            r_flush     <= '0;
            r_ss_armed  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_hist <= w_sclk;
            r_ss_hist   <= w_ss;
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            // Only a select seen high after the chain flushes can start a
            // frame, so a select held low through reset release is ignored.
            if (r_flush[SYNC_STAGES-1] && w_ss) begin
                r_ss_armed <= 1'b1;
            end
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sclk & r_sclk_hist;
    assign w_ss_fall   = r_ss_armed & r_ss_hist & ~w_ss;
    assign w_ss_rise   = w_ss & ~r_ss_hist;
    assign w_ssact     = ~w_ss;

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame sequencing; a select release overrides every state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_ss_fall) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SHIFT;
            S_SHIFT: if (w_sclk_rise && (r_bitcnt == CNTW'(DATABITS - 1))) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_WAITF;
            S_WAITF: if (w_sclk_fall) w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
        if (w_ss_rise) begin
            w_state_next = S_IDLE;
        end
    end

    // Shift registers, bit counter and rx holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_rx <= '0;
            r_shift_tx <= '0;
            r_rx_hold  <= '0;
            r_bitcnt   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_bitcnt   <= '0;
                    r_shift_tx <= r_tx_primed ? r_tx_hold : '0;
                end
                S_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_shift_rx <= {r_shift_rx[DATABITS-2:0], w_mosi};
                        r_bitcnt   <= r_bitcnt + CNTW'(1);
                    end
                    if (w_sclk_fall && (r_bitcnt < CNTW'(DATABITS))) begin
                        r_shift_tx <= {r_shift_tx[DATABITS-2:0], 1'b0};
                    end
                end
                S_DONE: r_rx_hold <= r_shift_rx;
                default: ;
            endcase
        end
    end

    // Bus strobe history: each access strobes once on its first cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_req_d <= 1'b0;
            r_wr_req_d <= 1'b0;
        end else begin
            r_rd_req_d <= w_rd_req;
            r_wr_req_d <= w_wr_req;
        end
    end

    assign w_rd_req     = bus.spi_select & ~bus.read_n;
    assign w_wr_req     = bus.spi_select & ~bus.write_n;
    assign w_rd_stb     = w_rd_req & ~r_rd_req_d;
    assign w_wr_stb     = w_wr_req & ~r_wr_req_d;
    assign w_rx_read    = w_rd_stb & (bus.mem_addr == 3'd0);
    assign w_tx_write   = w_wr_stb & (bus.mem_addr == 3'd1);
    assign w_stat_write = w_wr_stb & (bus.mem_addr == 3'd2);
    assign w_ctrl_write = w_wr_stb & (bus.mem_addr == 3'd3);

    // Status flags, tx holding register and control register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rrdy        <= 1'b0;
            r_roe         <= 1'b0;
            r_toe         <= 1'b0;
            r_tur         <= 1'b0;
            r_tx_primed   <= 1'b0;
            r_tx_hold     <= '0;
            r_tur_pending <= 1'b0;
            r_control     <= '0;
        end else begin
            if (r_state == S_DONE) begin
                r_rrdy <= 1'b1;
            end else if (w_rx_read) begin
                r_rrdy <= 1'b0;
            end

            if ((r_state == S_DONE) && r_rrdy) begin
                r_roe <= 1'b1;
            end else if (w_stat_write) begin
                r_roe <= 1'b0;
            end

            if (w_tx_write && r_tx_primed) begin
                r_toe <= 1'b1;
            end else if (w_stat_write) begin
                r_toe <= 1'b0;
            end

            if (w_tx_write && !r_tx_primed) begin
                r_tx_primed <= 1'b1;
                r_tx_hold   <= bus.data_from_cpu[DATABITS-1:0];
            end else if ((r_state == S_LOAD) && r_tx_primed) begin
                r_tx_primed <= 1'b0;
            end

            // WAITF reaches LOAD on the trailing SCLK fall of every frame, so
            // an empty load only counts as an underrun once the next frame
            // actually clocks its first bit.
            if (r_state == S_IDLE) begin
                r_tur_pending <= 1'b0;
            end else if (r_state == S_LOAD) begin
                r_tur_pending <= ~r_tx_primed;
            end else if ((r_state == S_SHIFT) && w_sclk_rise) begin
                r_tur_pending <= 1'b0;
            end

            if ((r_state == S_SHIFT) && w_sclk_rise && r_tur_pending) begin
                r_tur <= 1'b1;
            end else if (w_stat_write) begin
                r_tur <= 1'b0;
            end

            if (w_ctrl_write) begin
                r_control <= bus.data_from_cpu & CTRL_MASK;
            end
        end
    end

    // Status word assembly.
    always_comb begin
        w_status    = '0;
        w_status[9] = w_ssact;
        w_status[8] = r_roe | r_toe | r_tur;
        w_status[7] = r_rrdy;
        w_status[6] = ~r_tx_primed;
        w_status[5] = ~r_tx_primed & ~w_ssact;
        w_status[4] = r_toe;
        w_status[3] = r_roe;
        w_status[2] = r_tur;
    end

    // Read-data mux by register address.
    always_comb begin
        w_rdata = '0;
        case (bus.mem_addr)
            3'd0:    w_rdata = 16'(r_rx_hold);
            3'd2:    w_rdata = w_status;
            3'd3:    w_rdata = r_control;
            default: w_rdata = '0;
        endcase
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_to_cpu <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_data_to_cpu <= w_rdata;
            r_irq         <= |(w_status & r_control);
        end
    end

    assign bus.data_to_cpu = r_data_to_cpu;
    assign bus.irq         = r_irq;
    assign MISO            = r_shift_tx[DATABITS-1];
    assign MISO_oe         = w_ssact;

endmodule
